estimate_seq: RTL and testbench
===============================

# estimate_seq

Sequencer for the binarized `estimate` datapath (32 cores, 64-bit activation words, 1024-bit parameter RAM). It owns the command bus, parameter address and data bus into `estimate`. For each output word it runs the full command sequence: init, accumulate with 2×2 max-pool, normalize, then activate. It pulls input activation words from an upstream valid/ready stream and presents the 64-bit activation result to a downstream valid/ready consumer.

## Interface
- `N_WORDS`, 9 — accumulate cycles per pool window (input words per window)
- `N_POOL`, 4 — pool windows per output
- `clk` input 1 — clock
- `reset_n` input 1 — synchronous, active-low reset
- `start` input 1 — pulse; latches `cfg_base` and `cfg_count`; ignored while `busy`
- `cfg_base` input 16 — parameter RAM address of the first weight row
- `cfg_count` input 16 — number of output words to produce
- `busy` output 1 — high from the cycle after an accepted `start` until the last output is accepted
- `in_valid` input 1 — input activation word valid
- `in_ready` output 1 — high only in ACC
- `in_data` input 64 — input activation word
- `est_com` output 3 — to `estimate.com`
- `est_addr` output 16 — to `estimate.addr`
- `est_data` output 64 — to `estimate.data`
- `est_activ` input 64 — from `estimate.activ`
- `out_valid` output 1 — result valid
- `out_ready` input 1 — consumer accepts
- `out_activ` output 64 — equals `est_activ` while `out_valid` is high

## Operation
- Command codes: INI=0, ACC=1, POOL=2, NORM=3, ACTV=4, NOP=7. NOP is a no-op in both core stages.
- `est_com`, `est_addr` and `est_data` are combinational from the state registers and the input handshake. When not otherwise stated, `est_com`=NOP, `est_data`=0 and `est_addr` holds its last value.
- States are IDLE, INI, ACC, POOL, NORM, ACTV, DRAIN, OUT.
- IDLE: on `start`, latch `wbase`=`cfg_base` and `remain`=`cfg_count`. If `cfg_count`==0, stay in IDLE with `busy` low. Otherwise go to INI.
- INI, one cycle: `est_com`=INI, `est_data`=0, so acc is cleared and pool is set to 0x8000. Clear `k` and `win`. Go to ACC.
- ACC:
  - On `in_valid`&&`in_ready`: `est_com`=ACC, `est_data`=`in_data`, `est_addr`=`wbase`+`k`, then `k`++.
  - With no transfer: `est_com`=NOP and `k` holds.
  - After the transfer with `k`==`N_WORDS`-1, go to POOL.
- POOL, one cycle: `est_com`=POOL, `est_data`=0, `k`=0, `win`++.
  - If `win`==`N_POOL`-1, go to NORM; else go to ACC.
- NORM, one cycle: `est_com`=NORM, `est_addr`=`wbase`+`N_WORDS`. Go to ACTV.
- ACTV, one cycle: `est_com`=ACTV. `est_addr` holds the NORM address, because the activate threshold comes from the norm row. Go to DRAIN.
- DRAIN: two cycles of NOP, then OUT.
- OUT: `out_valid`=1 until `out_ready`. On acceptance:
  - `wbase` += `N_WORDS`+1 (16-bit wrap).
  - `remain`--.
  - If `remain` reaches 0, go to IDLE; else go to INI.
- Reset, synchronous when `reset_n`=0, including mid-sequence:
  - state=IDLE, `busy`=0, `in_ready`=0, `out_valid`=0.
  - `est_com`=NOP, `est_addr`=0, `est_data`=0.
  - All counters 0.
  - The datapath is not flushed; the next INI reinitializes it.
- Counters are 16-bit unsigned. `k` and `win` are sized `$clog2` of their limits, at least 1 bit.

## Timing
- Numbering starts with INI at cycle 0, with no stalls:
  - ACC/POOL occupy cycles 1..`N_POOL`*(`N_WORDS`+1).
  - With defaults: NORM at 41, ACTV at 42, DRAIN at 43–44, `out_valid` first high at 45.
- `estimate` latencies: command to acc/pool update is 2 edges; ACTV to valid `est_activ` is 3 cycles. DRAIN covers that gap.
- Each cycle with `in_valid` low in ACC adds exactly one cycle.
- `out_ready` low holds OUT. `est_activ` stays stable because no ACTV is issued.
- OUT accepted at cycle t puts the next INI at t+1.
- `busy` and `in_ready` are never high in IDLE.

## Configuration
- `ESTIMATE_SEQ_PERF_EN` defined adds two outputs, both cleared by reset or an accepted `start`:
  - `perf_stall` (32 bits): cycles in ACC with `in_valid` low.
  - `perf_wait` (32 bits): cycles in OUT with `out_ready` low.
- Undefined: those ports and their counters do not exist, and the remaining behaviour is identical.

## Structure
- Package `estimate_pkg` holds:
  - command code constants (INI/ACC/POOL/NORM/ACTV/NOP) as a 3-bit typedef enum;
  - the state typedef enum;
  - widths: `ADDR_W`=16, `DATA_W`=64, `PARAM_W`=1024.
- Sub-module `estimate_seq_perf` holds the two saturating counters. It is instantiated only under `ESTIMATE_SEQ_PERF_EN`.

## Test plan
- Defaults, `cfg_base`=0x0100, `cfg_count`=1, `in_valid` always 1, `out_ready` always 1:
  - `est_com` sequence 0,(1×9,2)×4,3,4,7,7;
  - `est_addr` 0x0100..0x0108 repeated, then 0x0109;
  - `out_valid` at cycle 45 with `out_activ`=`est_activ`.
- `cfg_count`=3: `est_addr` bases are 0x0100, 0x010A, 0x0114; three `out_valid` pulses 46 cycles apart; `busy` falls after the third.
- `in_valid` low for 5 cycles mid-ACC: 5 NOP commands inserted, `k` frozen, `out_valid` at cycle 50.
- `out_ready` low 10 cycles in OUT: `out_valid`/`out_activ` held, no ACTV issued, next INI the cycle after acceptance.
- `reset_n` low in ACC of output 2: all outputs at reset values next cycle; a new `start` gives the same cycle-45 result as the first test.
- `cfg_count`=0 and `start` while `busy`: no command other than NOP is issued and the configuration is unchanged.

Source files
------------

// File: rtl/estimate_pkg.sv
// Shared command codes, sequencer states and bus widths for the estimate datapath.
package estimate_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 64;
  localparam int PARAM_W = 1024;

  typedef enum logic [2:0] {
    CMD_INI  = 3'd0,
    CMD_ACC  = 3'd1,
    CMD_POOL = 3'd2,
    CMD_NORM = 3'd3,
    CMD_ACTV = 3'd4,
    CMD_NOP  = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INI,
    ST_ACC,
    ST_POOL,
    ST_NORM,
    ST_ACTV,
    ST_DRAIN,
    ST_OUT
  } state_e;

endpackage

// File: rtl/estimate_seq_perf.sv
// Saturating stall/wait event counters for the estimate sequencer.
module estimate_seq_perf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        stall_inc,
  input  logic        wait_inc,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_wait
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      perf_stall <= '0;
      perf_wait  <= '0;
    end else begin
      if (stall_inc) perf_stall <= sat_inc(perf_stall);
      if (wait_inc)  perf_wait  <= sat_inc(perf_wait);
    end
  end

endmodule

// File: rtl/estimate_seq.sv
// Command sequencer for the binarized estimate datapath: INI, ACC/POOL windows, NORM, ACTV, result handoff.
// Define ESTIMATE_SEQ_PERF_EN to add the perf_stall / perf_wait counter outputs.
module estimate_seq
  import estimate_pkg::*;
#(
  parameter int N_WORDS = 9,
  parameter int N_POOL  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_count,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [2:0]        est_com,
  output logic [ADDR_W-1:0] est_addr,
  output logic [DATA_W-1:0] est_data,
  input  logic [DATA_W-1:0] est_activ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_activ
`ifdef ESTIMATE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_wait
`endif
);

  localparam int K_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int W_W = (N_POOL > 1) ? $clog2(N_POOL) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);
  localparam logic [W_W-1:0] W_LAST = W_W'(N_POOL - 1);

  state_e            state;
  logic [ADDR_W-1:0] wbase;
  logic [15:0]       remain;
  logic [K_W-1:0]    k;
  logic [W_W-1:0]    win;
  logic [ADDR_W-1:0] addr_q;

  cmd_e              com;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign out_activ = out_valid ? est_activ : '0;

  assign est_com  = com;
  assign est_addr = addr_n;
  assign est_data = data_n;

  always_comb begin
    com    = CMD_NOP;
    data_n = '0;
    addr_n = addr_q;
    case (state)
      ST_INI:  com = CMD_INI;
      ST_ACC: begin
        if (in_valid) begin
          com    = CMD_ACC;
          data_n = in_data;
          addr_n = wbase + ADDR_W'(k);
        end
      end
      ST_POOL: com = CMD_POOL;
      ST_NORM: begin
        com    = CMD_NORM;
        addr_n = wbase + ADDR_W'(N_WORDS);
      end
      // Address is left on the norm row: the activate threshold lives there.
      ST_ACTV: com = CMD_ACTV;
      default: com = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      wbase  <= '0;
      remain <= '0;
      k      <= '0;
      win    <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= addr_n;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wbase  <= cfg_base;
            remain <= cfg_count;
            if (cfg_count != 16'd0) state <= ST_INI;
          end
        end
        ST_INI: begin
          k     <= '0;
          win   <= '0;
          state <= ST_ACC;
        end
        ST_ACC: begin
          if (in_valid) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_POOL;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_POOL: begin
          k     <= '0;
          win   <= win + 1'b1;
          state <= (win == W_LAST) ? ST_NORM : ST_ACC;
        end
        ST_NORM: state <= ST_ACTV;
        ST_ACTV: begin
          k     <= '0;
          state <= ST_DRAIN;
        end
        // k doubles as the two-cycle drain timer covering the activation latency.
        ST_DRAIN: begin
          if (k[0]) begin
            k     <= '0;
            state <= ST_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            wbase  <= wbase + ADDR_W'(N_WORDS + 1);
            remain <= remain - 16'd1;
            state  <= (remain == 16'd1) ? ST_IDLE : ST_INI;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ESTIMATE_SEQ_PERF_EN
  estimate_seq_perf u_perf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start && (state == ST_IDLE)),
    .stall_inc ((state == ST_ACC) && !in_valid),
    .wait_inc  ((state == ST_OUT) && !out_ready),
    .perf_stall(perf_stall),
    .perf_wait (perf_wait)
  );
`endif

endmodule

// File: tb/tb_estimate_seq.sv
// Directed bench for estimate_seq: command/address sequence, stalls, output backpressure, reset and start filtering.
module tb_estimate_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_count = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [2:0]  est_com;
  logic [15:0] est_addr;
  logic [63:0] est_data;
  logic [63:0] est_activ = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_activ;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [2:0]  com;
    logic [15:0] addr;
    logic        ca;
    logic        iv;
    logic [63:0] din;
  } ent_t;

  ent_t q[$];

  estimate_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .cfg_base (cfg_base),
    .cfg_count(cfg_count),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .est_com  (est_com),
    .est_addr (est_addr),
    .est_data (est_data),
    .est_activ(est_activ),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_activ(out_activ)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic ent_t mk(input logic [2:0] com, input logic [15:0] addr, input logic ca,
                              input logic iv, input logic [63:0] din);
    ent_t e;
    e.com = com; e.addr = addr; e.ca = ca; e.iv = iv; e.din = din;
    return e;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_com", 64'(est_com), 64'd7);
    chk("rst_addr", 64'(est_addr), 64'd0);
    chk("rst_data", est_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the INI cycle (or next IDLE cycle).
  task automatic start_seq(input logic [15:0] base, input logic [15:0] count);
    start = 1'b1;
    cfg_base = base;
    cfg_count = count;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_output(input logic [15:0] base, input int stall_len, input int wait_len,
                            input bit last, input int stop_after, input bit glitch);
    logic [15:0] la;
    la = base;
    q.delete();
    q.push_back(mk(3'd0, 16'h0, 1'b0, 1'b1, 64'h0));
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 9; j++) begin
        if (w == 1 && j == 4)
          for (int s = 0; s < stall_len; s++)
            q.push_back(mk(3'd7, la, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
        la = base + 16'(j);
        q.push_back(mk(3'd1, la, 1'b1, 1'b1, {16'hC0DE, base, 16'h0, 8'(w), 8'(j)}));
      end
      q.push_back(mk(3'd2, la, 1'b1, 1'b1, 64'h0));
    end
    la = base + 16'd9;
    q.push_back(mk(3'd3, la, 1'b1, 1'b1, 64'h0));
    q.push_back(mk(3'd4, la, 1'b1, 1'b1, 64'h0));
    q.push_back(mk(3'd7, la, 1'b1, 1'b1, 64'h0));
    q.push_back(mk(3'd7, la, 1'b1, 1'b1, 64'h0));
    est_activ = {32'hACDC_0000, base, 16'h5A5A};

    for (int i = 0; i < q.size(); i++) begin
      if (stop_after > 0 && i == stop_after) return;
      in_valid = q[i].iv;
      in_data  = q[i].din;
      if (glitch && i == 20) begin
        start = 1'b1; cfg_base = 16'h0200; cfg_count = 16'd5;
      end else begin
        start = 1'b0;
      end
      #1;
      chk("com", 64'(est_com), 64'(q[i].com));
      if (q[i].ca) chk("addr", 64'(est_addr), 64'(q[i].addr));
      chk("data", est_data, (q[i].com == 3'd1) ? q[i].din : 64'h0);
      chk("seq_out_valid", 64'(out_valid), 64'd0);
      chk("seq_busy", 64'(busy), 64'd1);
      chk("seq_in_ready", 64'(in_ready), 64'((q[i].com == 3'd1) || !q[i].iv));
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;

    for (int n = 0; n <= wait_len; n++) begin
      out_ready = (n == wait_len);
      #1;
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_activ", out_activ, est_activ);
      chk("out_com", 64'(est_com), 64'd7);
      chk("out_addr", 64'(est_addr), 64'(la));
      chk("out_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid = 1'b1;

    if (last) begin
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_out_valid", 64'(out_valid), 64'd0);
      chk("end_com", 64'(est_com), 64'd7);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    reset_n = 1'b1;

    // Single output, no stalls: result at cycle 45.
    start_seq(16'h0100, 16'd1);
    run_output(16'h0100, 0, 0, 1'b1, 0, 1'b0);

    // Three outputs back to back with advancing weight bases.
    start_seq(16'h0100, 16'd3);
    run_output(16'h0100, 0, 0, 1'b0, 0, 1'b0);
    run_output(16'h010A, 0, 0, 1'b0, 0, 1'b0);
    run_output(16'h0114, 0, 0, 1'b1, 0, 1'b0);

    // Input stall of 5 cycles, then 10 cycles of output backpressure.
    start_seq(16'h0100, 16'd2);
    run_output(16'h0100, 5, 0, 1'b0, 0, 1'b0);
    run_output(16'h010A, 0, 10, 1'b1, 0, 1'b0);

    // Reset during ACC of the second output, then a clean restart.
    start_seq(16'h0100, 16'd3);
    run_output(16'h0100, 0, 0, 1'b0, 0, 1'b0);
    run_output(16'h010A, 0, 0, 1'b0, 5, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals();
    reset_n = 1'b1;
    start_seq(16'h0100, 16'd1);
    run_output(16'h0100, 0, 0, 1'b1, 0, 1'b0);

    // Zero-count start is ignored; start while busy does not disturb the run.
    start_seq(16'h0300, 16'd0);
    for (int c = 0; c < 4; c++) begin
      chk("zero_com", 64'(est_com), 64'd7);
      chk("zero_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    start_seq(16'h0100, 16'd1);
    run_output(16'h0100, 0, 0, 1'b1, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_com", 64'(est_com), 64'd7);
      chk("post_busy", 64'(busy), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
